// File: rtl/region_draw_engine_if.sv
// Command/pixel bus between the graphics controller (master) and region_draw_engine (slave).
// Signal names follow the controller's existing command and VGA-adapter naming.
interface region_draw_engine_if;
  logic       drawMoney;
  logic       drawSelection;
  logic       drawUpgrade;
  logic       black;
  logic [1:0] sel_idx;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic       overflow;

  modport master (
    output drawMoney, drawSelection, drawUpgrade, black, sel_idx,
    input  x, y, colour, plot, busy, done, overflow
  );

  modport slave (
    input  drawMoney, drawSelection, drawUpgrade, black, sel_idx,
    output x, y, colour, plot, busy, done, overflow
  );
endinterface

// File: rtl/region_draw_engine.sv
// Rectangle sweep engine: turns one-cycle draw commands into (x, y, colour, plot) writes.
// Optional macro SEL_OUTLINE_EN: selection/erase sweeps plot only the slot border.
module region_draw_engine #(
  parameter logic [7:0] MONEY_X    = 8'd4,
  parameter logic [6:0] MONEY_Y    = 7'd4,
  parameter logic [7:0] MONEY_W    = 8'd32,
  parameter logic [6:0] MONEY_H    = 7'd8,
  parameter logic [7:0] SLOT_X     = 8'd100,
  parameter logic [6:0] SLOT_Y     = 7'd20,
  parameter logic [7:0] SLOT_W     = 8'd40,
  parameter logic [6:0] SLOT_H     = 7'd16,
  parameter logic [6:0] SLOT_PITCH = 7'd20,
  parameter logic [2:0] MONEY_COL  = 3'b110,
  parameter logic [2:0] UPG_COL    = 3'b010,
  parameter logic [2:0] SEL_COL    = 3'b111
) (
  input  logic                 clock,
  input  logic                 resetn,
  region_draw_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {M_MONEY = 2'd0, M_UPG = 2'd1, M_SEL = 2'd2, M_ERASE = 2'd3} mode_t;

`ifdef SEL_OUTLINE_EN
  localparam logic OUTLINE = 1'b1;
`else
  localparam logic OUTLINE = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [7:0] cx_q, cx_d, bx_q, bx_d, w_q, w_d, x_q, x_d;
  logic [6:0] cy_q, cy_d, by_q, by_d, h_q, h_d, y_q, y_d;
  logic [2:0] col_q, col_d, colour_q, colour_d;
  logic       marker_q, marker_d, plot_q, plot_d, done_q, done_d, ovf_q, ovf_d;
  logic       pend_v_q, pend_v_d;
  mode_t      pend_mode_q, pend_mode_d;
  logic [1:0] pend_idx_q, pend_idx_d, last_sel_q, last_sel_d;

  logic       cmd_v_s, cmd_taken_s, load_s, last_s, border_s;
  mode_t      cmd_mode_s, ld_mode_s;
  logic [1:0] cmd_idx_s, ld_idx_s;

  // Command decode, state transitions, pending buffer and sweep datapath.
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    bx_d        = bx_q;
    by_d        = by_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    marker_d    = marker_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    pend_v_d    = pend_v_q;
    pend_mode_d = pend_mode_q;
    pend_idx_d  = pend_idx_q;
    last_sel_d  = last_sel_q;
    cmd_v_s     = 1'b1;
    cmd_mode_s  = M_MONEY;
    cmd_idx_s   = 2'd0;
    cmd_taken_s = 1'b0;
    load_s      = 1'b0;
    ld_mode_s   = M_MONEY;
    ld_idx_s    = 2'd0;

    if (bus.drawUpgrade) begin
      cmd_mode_s = M_UPG;
      cmd_idx_s  = bus.sel_idx;
    end else if (bus.drawSelection && bus.black) begin
      cmd_mode_s = M_ERASE;
      cmd_idx_s  = last_sel_q;
    end else if (bus.drawSelection) begin
      cmd_mode_s = M_SEL;
      cmd_idx_s  = bus.sel_idx;
    end else if (bus.drawMoney) begin
      cmd_mode_s = M_MONEY;
    end else begin
      cmd_v_s = 1'b0;
    end

    // Pending wins in IDLE; a simultaneous new command refills the buffer.
    if (state_q == IDLE && pend_v_q) begin
      load_s      = 1'b1;
      ld_mode_s   = pend_mode_q;
      ld_idx_s    = pend_idx_q;
      pend_v_d    = cmd_v_s;
      pend_mode_d = cmd_mode_s;
      pend_idx_d  = cmd_idx_s;
      cmd_taken_s = cmd_v_s;
    end else if (state_q == IDLE && cmd_v_s) begin
      load_s      = 1'b1;
      ld_mode_s   = cmd_mode_s;
      ld_idx_s    = cmd_idx_s;
      cmd_taken_s = 1'b1;
    end else if (cmd_v_s && !pend_v_q) begin
      pend_v_d    = 1'b1;
      pend_mode_d = cmd_mode_s;
      pend_idx_d  = cmd_idx_s;
      cmd_taken_s = 1'b1;
    end else if (cmd_v_s) begin
      ovf_d = 1'b1;
    end else begin
      cmd_taken_s = 1'b0;
    end

    if (cmd_taken_s && cmd_mode_s == M_SEL) begin
      last_sel_d = bus.sel_idx;
    end else begin
      last_sel_d = last_sel_q;
    end

    last_s   = (cx_q == w_q - 8'd1) && (cy_q == h_q - 7'd1);
    border_s = (cx_q == 8'd0) || (cx_q == w_q - 8'd1) || (cy_q == 7'd0) || (cy_q == h_q - 7'd1);

    case (state_q)
      IDLE: begin
        if (load_s) begin
          cx_d    = 8'd0;
          cy_d    = 7'd0;
          state_d = SWEEP;
          case (ld_mode_s)
            M_MONEY: begin
              bx_d = MONEY_X; by_d = MONEY_Y; w_d = MONEY_W; h_d = MONEY_H;
              col_d = MONEY_COL; marker_d = 1'b0;
            end
            default: begin
              bx_d = SLOT_X;
              by_d = SLOT_Y + ({5'd0, ld_idx_s} * SLOT_PITCH);
              w_d  = SLOT_W;
              h_d  = SLOT_H;
              marker_d = (ld_mode_s == M_SEL) || (ld_mode_s == M_ERASE);
              if (ld_mode_s == M_UPG) begin
                col_d = UPG_COL;
              end else if (ld_mode_s == M_SEL) begin
                col_d = SEL_COL;
              end else begin
                col_d = 3'b000;
              end
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        x_d      = bx_q + cx_q;
        y_d      = by_q + cy_q;
        colour_d = col_q;
        plot_d   = !(OUTLINE && marker_q) || border_s;
        if (cx_q == w_q - 8'd1) begin
          cx_d = 8'd0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = SWEEP;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cx_q        <= 8'd0;
      cy_q        <= 7'd0;
      bx_q        <= 8'd0;
      by_q        <= 7'd0;
      w_q         <= 8'd0;
      h_q         <= 7'd0;
      col_q       <= 3'b000;
      marker_q    <= 1'b0;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      colour_q    <= 3'b000;
      plot_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_mode_q <= M_MONEY;
      pend_idx_q  <= 2'd0;
      last_sel_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      marker_q    <= marker_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      pend_v_q    <= pend_v_d;
      pend_mode_q <= pend_mode_d;
      pend_idx_q  <= pend_idx_d;
      last_sel_q  <= last_sel_d;
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != IDLE) || pend_v_q;

endmodule
